// File: rtl/pool_engine_param.sv
`default_nettype none
// ============================================================================
//  Module   : pool_engine_param
//  Purpose  : Per-channel POOL_SIZE x POOL_SIZE max-pooling on packed float32
//             samples, with optional ReLU, frame window counting and abort.
//  Revision : 1.0 - initial release
// ============================================================================
module pool_engine_param #(
    parameter int DATA_WIDTH    = 32,
    parameter int CHANNELS      = 12,
    parameter int POOL_SIZE     = 2,
    parameter int FRAME_WINDOWS = 144
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clear,
    input  logic                           relu_en,
    input  logic                           in_valid,
    input  logic [CHANNELS*DATA_WIDTH-1:0] data_in,
    output logic                           out_valid,
    output logic [CHANNELS*DATA_WIDTH-1:0] pooling_output,
    output logic                           frame_done,
    output logic                           busy
);

    localparam int c_win_len = POOL_SIZE * POOL_SIZE;
    localparam int c_scnt_w  = (c_win_len > 1) ? $clog2(c_win_len) : 1;
    localparam int c_wcnt_w  = (FRAME_WINDOWS > 1) ? $clog2(FRAME_WINDOWS) : 1;
    localparam logic [c_scnt_w-1:0] c_last_sample = c_scnt_w'(c_win_len - 1);
    localparam logic [c_wcnt_w-1:0] c_last_window = c_wcnt_w'(FRAME_WINDOWS - 1);

    logic [c_scnt_w-1:0] r_sample_cnt;
    logic [c_wcnt_w-1:0] r_win_cnt;
    logic                r_relu;
    logic                r_out_valid;
    logic                r_frame_done;

    logic w_first;
    logic w_last;
    logic w_accept;
    logic w_relu_eff;

    // Returns 1 only when the new sample is strictly larger than the held one.
    // Sign-magnitude compare; both zeros (either sign) tie so the held value stays.
    function automatic logic f_new_wins(input logic [DATA_WIDTH-1:0] a_new,
                                        input logic [DATA_WIDTH-1:0] b_held);
        logic w_both_zero;
        logic w_res;
        w_both_zero = (a_new[DATA_WIDTH-2:0] == '0) && (b_held[DATA_WIDTH-2:0] == '0);
        if (w_both_zero)
            w_res = 1'b0;
        else if (a_new[DATA_WIDTH-1] != b_held[DATA_WIDTH-1])
            w_res = ~a_new[DATA_WIDTH-1];
        else if (!a_new[DATA_WIDTH-1])
            w_res = a_new[DATA_WIDTH-2:0] > b_held[DATA_WIDTH-2:0];
        else
            w_res = a_new[DATA_WIDTH-2:0] < b_held[DATA_WIDTH-2:0];
        return w_res;
    endfunction

    assign w_first  = (r_sample_cnt == '0);
    assign w_last   = (r_sample_cnt == c_last_sample);
    assign w_accept = in_valid && !clear;
    // With POOL_SIZE=1 the first beat is also the last, so use the live input.
    assign w_relu_eff = w_first ? relu_en : r_relu;

    assign out_valid  = r_out_valid;
    assign frame_done = r_frame_done;
    assign busy       = (r_sample_cnt != '0);

    // Sample/window counters, ReLU latch and the one-cycle result pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sample_cnt <= '0;
            r_win_cnt    <= '0;
            r_relu       <= 1'b0;
            r_out_valid  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_out_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            if (clear) begin
                r_sample_cnt <= '0;
                r_win_cnt    <= '0;
            end else if (in_valid) begin
                if (w_first)
                    r_relu <= relu_en;
                if (w_last) begin
                    r_sample_cnt <= '0;
                    r_out_valid  <= 1'b1;
                    if (r_win_cnt == c_last_window) begin
                        r_win_cnt    <= '0;
                        r_frame_done <= 1'b1;
                    end else begin
                        r_win_cnt <= r_win_cnt + c_wcnt_w'(1);
                    end
                end else begin
                    r_sample_cnt <= r_sample_cnt + c_scnt_w'(1);
                end
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [DATA_WIDTH-1:0] r_max;
        logic [DATA_WIDTH-1:0] r_pool;
        logic [DATA_WIDTH-1:0] w_in;
        logic [DATA_WIDTH-1:0] w_next;
        logic [DATA_WIDTH-1:0] w_out;

        assign w_in   = data_in[(CHANNELS-g)*DATA_WIDTH-1 -: DATA_WIDTH];
        assign w_next = (w_first || f_new_wins(w_in, r_max)) ? w_in : r_max;
        assign w_out  = (w_relu_eff && w_next[DATA_WIDTH-1]) ? '0 : w_next;
        assign pooling_output[(CHANNELS-g)*DATA_WIDTH-1 -: DATA_WIDTH] = r_pool;

        // Running maximum for this channel; first beat of a window reloads it.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                r_max <= '0;
            else if (w_accept)
                r_max <= w_next;
        end

        // Result register, updated on the last beat and held until the next.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                r_pool <= '0;
            else if (w_accept && w_last)
                r_pool <= w_out;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pool_engine_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pool_engine_param
//  Purpose  : Directed self-checking bench for pool_engine_param
//             (CHANNELS=12, POOL_SIZE=2, FRAME_WINDOWS=3).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pool_engine_param;

    localparam int c_ch = 12;
    localparam int c_dw = 32;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 clear = 1'b0;
    logic                 relu_en = 1'b0;
    logic                 in_valid = 1'b0;
    logic [c_ch*c_dw-1:0] data_in;
    logic                 out_valid;
    logic [c_ch*c_dw-1:0] pooling_output;
    logic                 frame_done;
    logic                 busy;

    logic [c_dw-1:0] chv [c_ch];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Pack the per-channel stimulus words, channel 0 in the MSBs.
    always_comb begin
        data_in = '0;
        for (int c = 0; c < c_ch; c++)
            data_in[(c_ch-c)*c_dw-1 -: c_dw] = chv[c];
    end

    pool_engine_param #(
        .DATA_WIDTH(32), .CHANNELS(12), .POOL_SIZE(2), .FRAME_WINDOWS(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .relu_en(relu_en),
        .in_valid(in_valid), .data_in(data_in), .out_valid(out_valid),
        .pooling_output(pooling_output), .frame_done(frame_done), .busy(busy)
    );

    function automatic logic [c_dw-1:0] out_ch(input int c);
        return pooling_output[(c_ch-c)*c_dw-1 -: c_dw];
    endfunction

    task automatic zero_inputs();
        for (int c = 0; c < c_ch; c++) chv[c] = '0;
    endtask

    // One accepted beat: inputs set at posedge+1, returns at next posedge+1.
    task automatic beat(input int c, input logic [c_dw-1:0] v, input logic r);
        chv[c] = v; relu_en = r; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_clear();
        clear = 1'b1; @(posedge clk); #1; clear = 1'b0;
    endtask

    task automatic test_reset();
        zero_inputs();
        rst_n = 1'b0;
        idle(2);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (pooling_output !== '0) begin bad++; $display("FAIL reset_pool got=%h exp=0", pooling_output); end
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_basic_max();
        do_clear(); zero_inputs();
        chv[11] = 32'h3F000000; beat(0, 32'h3F800000, 1'b0);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b exp=1", busy); end
        chv[11] = 32'h40400000; beat(0, 32'h40000000, 1'b0);
        chv[11] = 32'h3F800000; beat(0, 32'hBF800000, 1'b0);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid got=%b exp=0", out_valid); end
        chv[11] = 32'h40000000; beat(0, 32'h3F000000, 1'b0);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b exp=1", out_valid); end
        total++; if (out_ch(0) !== 32'h40000000) begin bad++; $display("FAIL basic_ch0 got=%h exp=40000000", out_ch(0)); end
        total++; if (out_ch(11) !== 32'h40400000) begin bad++; $display("FAIL basic_ch11 got=%h exp=40400000", out_ch(11)); end
        total++; if (out_ch(5) !== 32'h00000000) begin bad++; $display("FAIL basic_ch5 got=%h exp=00000000", out_ch(5)); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_end got=%b exp=0", busy); end
        idle(1);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_pulse_width got=%b exp=0", out_valid); end
    endtask

    task automatic test_negative_relu();
        do_clear(); zero_inputs();
        beat(1, 32'hC0000000, 1'b0); beat(1, 32'hBF800000, 1'b0);
        beat(1, 32'hC0400000, 1'b0); beat(1, 32'hC0800000, 1'b0);
        total++; if (out_ch(1) !== 32'hBF800000) begin bad++; $display("FAIL neg_ch1 got=%h exp=BF800000", out_ch(1)); end
        // relu_en high only on the first beat: the latched value must apply.
        chv[2] = 32'h3F800000;
        beat(1, 32'hC0000000, 1'b1); beat(1, 32'hBF800000, 1'b0);
        beat(1, 32'hC0400000, 1'b0); beat(1, 32'hC0800000, 1'b0);
        total++; if (out_ch(1) !== 32'h00000000) begin bad++; $display("FAIL relu_ch1 got=%h exp=00000000", out_ch(1)); end
        total++; if (out_ch(2) !== 32'h3F800000) begin bad++; $display("FAIL relu_ch2_pos got=%h exp=3F800000", out_ch(2)); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL relu_frame_done got=%b exp=0", frame_done); end
    endtask

    task automatic test_zero_tie();
        do_clear(); zero_inputs();
        beat(0, 32'h80000000, 1'b0); beat(0, 32'h00000000, 1'b0);
        beat(0, 32'hBF800000, 1'b0); beat(0, 32'hC0000000, 1'b0);
        total++; if (out_ch(0) !== 32'h80000000) begin bad++; $display("FAIL tie_ch0 got=%h exp=80000000", out_ch(0)); end
        beat(0, 32'h80000000, 1'b1); beat(0, 32'h00000000, 1'b1);
        beat(0, 32'hBF800000, 1'b1); beat(0, 32'hC0000000, 1'b1);
        total++; if (out_ch(0) !== 32'h00000000) begin bad++; $display("FAIL tie_relu_ch0 got=%h exp=00000000", out_ch(0)); end
    endtask

    task automatic test_frame();
        int pulses;
        do_clear(); zero_inputs();
        pulses = 0;
        for (int w = 0; w < 4; w++) begin
            for (int b = 0; b < 4; b++) begin
                beat(3, 32'h40000000 + 32'(w*16 + b), 1'b0);
                if (b < 3) begin
                    idle(2);
                    total++; if (busy !== 1'b1) begin bad++; $display("FAIL frame_gap_busy w=%0d b=%0d got=%b exp=1", w, b, busy); end
                    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL frame_gap_valid w=%0d b=%0d got=%b exp=0", w, b, out_valid); end
                end
            end
            if (out_valid === 1'b1) pulses++;
            total++; if (frame_done !== (w == 2)) begin bad++; $display("FAIL frame_done w=%0d got=%b exp=%b", w, frame_done, (w == 2)); end
            total++; if (out_ch(3) !== 32'h40000000 + 32'(w*16 + 3)) begin bad++; $display("FAIL frame_val w=%0d got=%h exp=%h", w, out_ch(3), 32'h40000000 + 32'(w*16 + 3)); end
            idle(1);
        end
        total++; if (pulses !== 4) begin bad++; $display("FAIL frame_pulses got=%0d exp=4", pulses); end
    endtask

    task automatic test_clear();
        logic [c_ch*c_dw-1:0] prev;
        do_clear(); zero_inputs();
        beat(0, 32'h3F800000, 1'b0);   // leaves win_cnt at 0, count from here
        beat(0, 32'h3F800000, 1'b0);
        beat(0, 32'h3F800000, 1'b0);
        beat(0, 32'h3F800000, 1'b0);   // window 1 of frame
        prev = pooling_output;
        beat(0, 32'h42C80000, 1'b0); beat(0, 32'h42C80000, 1'b0);
        chv[0] = 32'h43480000; in_valid = 1'b1; clear = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; clear = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL clear_valid got=%b exp=0", out_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL clear_busy got=%b exp=0", busy); end
        beat(0, 32'h3F800000, 1'b0); beat(0, 32'h40000000, 1'b0); beat(0, 32'h40400000, 1'b0);
        total++; if (pooling_output !== prev) begin bad++; $display("FAIL clear_hold got=%h exp=%h", pooling_output, prev); end
        beat(0, 32'h40800000, 1'b0);
        total++; if (out_ch(0) !== 32'h40800000) begin bad++; $display("FAIL clear_max got=%h exp=40800000", out_ch(0)); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL clear_frame got=%b exp=0", frame_done); end
    endtask

    task automatic test_async_reset();
        do_clear(); zero_inputs();
        for (int b = 0; b < 4; b++) beat(0, 32'h3F800000, 1'b0);   // win_cnt -> 1
        beat(0, 32'h40A00000, 1'b0); beat(0, 32'h40A00000, 1'b0); beat(0, 32'h40A00000, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        total++; if (pooling_output !== '0) begin bad++; $display("FAIL arst_pool got=%h exp=0", pooling_output); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL arst_busy got=%b exp=0", busy); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL arst_valid got=%b exp=0", out_valid); end
        @(posedge clk); #1; rst_n = 1'b1;
        idle(1);
        for (int w = 0; w < 3; w++) begin
            beat(0, 32'hC0000000, 1'b0); beat(0, 32'h40400000, 1'b0);
            beat(0, 32'h3F800000, 1'b0); beat(0, 32'h40000000, 1'b0);
            total++; if (out_ch(0) !== 32'h40400000) begin bad++; $display("FAIL arst_max w=%0d got=%h exp=40400000", w, out_ch(0)); end
            total++; if (frame_done !== (w == 2)) begin bad++; $display("FAIL arst_frame w=%0d got=%b exp=%b", w, frame_done, (w == 2)); end
        end
    endtask

    initial begin
        zero_inputs();
        test_reset();
        test_basic_max();
        test_negative_relu();
        test_zero_tie();
        test_frame();
        test_clear();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
